// File: rtl/lfclk_mon_pkg.sv
// Shared types for the low-frequency clock monitor: FSM states and fault codes.
// No logic; no latency or backpressure.
package lfclk_mon_pkg;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        ACQ    = 3'd1,
        TRACK  = 3'd2,
        LOCKED = 3'd3,
        FAULT  = 3'd4
    } lfclk_state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_RANGE = 2'b01;
    localparam logic [1:0] FC_LOST  = 2'b10;

    // Inclusive window test on an already-widened measurement.
    function automatic logic in_window(input logic [31:0] m,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (m >= lo) && (m <= hi);
    endfunction

endpackage

// File: rtl/lfclk_sync_edge.sv
// Two-flop synchroniser plus a third flop for rising-edge detection of an async clock.
// Latency: edge_o is high in the cycle after the 2nd sample of a new high level; no backpressure.
module lfclk_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/lfclk_monitor.sv
// Measures the slow clock period in clk cycles, tracks lock and raises sticky range/lost faults.
// Latency: all outputs registered, one cycle after the detected edge; no backpressure.
module lfclk_monitor
    import lfclk_mon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 488,
    parameter int TOL        = 8,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             lfclk_in,
    input  logic             clr_fault,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [31:0]       WIN_LO    = 32'(EXP_PERIOD - TOL);
    localparam logic [31:0]       WIN_HI    = 32'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  CNT_TO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_CNT);

    lfclk_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [GOOD_W-1:0] good_cnt_q;
    logic              tick_q;
    logic [CNT_W-1:0]  period_q;
    logic              period_vld_q;
    logic              locked_q;
    logic              fault_q;
    logic [1:0]        fault_code_q;

    logic              edge_det;
    logic [CNT_W:0]    meas;
    logic              in_win;
    logic              timeout_hit;
    logic [CNT_W-1:0]  cnt_inc;

    lfclk_sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (lfclk_in),
        .edge_o  (edge_det)
    );

    // The edge cycle itself counts toward the period, hence the +1.
    assign meas        = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign in_win      = in_window(32'(meas), WIN_LO, WIN_HI);
    assign timeout_hit = (cnt_q == CNT_TO) && !edge_det;
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Leaving FAULT restarts the count so a frozen lost-clock value cannot re-trip at once.
    always_comb begin
        cnt_d = cnt_q;
        unique case (state_q)
            OFF:     cnt_d = '0;
            FAULT:   cnt_d = clr_fault ? '0 : cnt_q;
            default: cnt_d = edge_det ? '0 : cnt_inc;
        endcase
        if (!enable) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            good_cnt_q   <= '0;
            tick_q       <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            cnt_q        <= cnt_d;
            tick_q       <= edge_det & enable;
            period_vld_q <= 1'b0;
            if (!enable) begin
                state_q      <= OFF;
                good_cnt_q   <= '0;
                period_q     <= '0;
                locked_q     <= 1'b0;
                fault_q      <= 1'b0;
                fault_code_q <= FC_NONE;
            end else begin
                case (state_q)
                    OFF: begin
                        state_q <= ACQ;
                    end
                    ACQ: begin
                        if (edge_det) begin
                            state_q    <= TRACK;
                            good_cnt_q <= '0;
                        end else if (timeout_hit) begin
                            state_q      <= FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_LOST;
                        end
                    end
                    TRACK: begin
                        if (edge_det) begin
                            period_q     <= meas[CNT_W-1:0];
                            period_vld_q <= 1'b1;
                            if (!in_win) begin
                                good_cnt_q <= '0;
                            end else if (good_cnt_q == LOCK_GOOD - GOOD_W'(1)) begin
                                good_cnt_q <= LOCK_GOOD;
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                            end else begin
                                good_cnt_q <= good_cnt_q + GOOD_W'(1);
                            end
                        end else if (timeout_hit) begin
                            state_q      <= FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_LOST;
                        end
                    end
                    LOCKED: begin
                        if (edge_det) begin
                            period_q     <= meas[CNT_W-1:0];
                            period_vld_q <= 1'b1;
                            if (!in_win) begin
                                state_q      <= FAULT;
                                locked_q     <= 1'b0;
                                fault_q      <= 1'b1;
                                fault_code_q <= FC_RANGE;
                            end
                        end else if (timeout_hit) begin
                            state_q      <= FAULT;
                            locked_q     <= 1'b0;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_LOST;
                        end
                    end
                    FAULT: begin
                        if (clr_fault) begin
                            state_q      <= ACQ;
                            good_cnt_q   <= '0;
                            fault_q      <= 1'b0;
                            fault_code_q <= FC_NONE;
                        end
                    end
                    default: begin
                        state_q <= OFF;
                    end
                endcase
            end
        end
    end

    assign tick       = tick_q;
    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign locked     = locked_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_lfclk_monitor.sv
// Bench for lfclk_monitor: cycle-number model compared every cycle, plus directed literal checks.
module tb_lfclk_monitor;

    localparam int CNT_W = 16;
    localparam int EXP   = 488;
    localparam int TOL   = 8;
    localparam int LOCKN = 4;
    localparam int TMO   = 1024;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             lfclk_in = 1'b0;
    logic             clr_fault = 1'b0;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             fault;
    logic [1:0]       fault_code;

    lfclk_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCKN), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .lfclk_in(lfclk_in),
        .clr_fault(clr_fault), .tick(tick), .period(period), .period_vld(period_vld),
        .locked(locked), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (time %0t)", nm, act, exp, $time);
        end
    endtask

    // Model: works on absolute cycle numbers; a period is the distance between edge cycles.
    localparam int M_OFF = 0, M_ACQ = 1, M_TRACK = 2, M_LOCKED = 3, M_FAULT = 4;
    int  mode = M_OFF;
    int  ncyc = 0;
    int  ref_cyc = 0;
    int  good = 0;
    int  m_len;
    bit  m_edge;
    bit  m_ok;
    bit  hist[$] = '{0, 0, 0};
    bit  e_tick = 0, e_pvld = 0, e_locked = 0, e_fault = 0;
    int  e_period = 0, e_code = 0;

    always @(posedge clk) begin
        ncyc++;
        if (!reset_n) begin
            hist = '{0, 0, 0};
            mode = M_OFF;
            good = 0;
            e_tick = 0; e_pvld = 0; e_locked = 0; e_fault = 0; e_period = 0; e_code = 0;
        end else begin
            // hist holds lfclk samples from cycles n-3, n-2, n-1.
            m_edge = hist[1] && !hist[0];
            hist.push_back(lfclk_in);
            hist.delete(0);
            e_tick = m_edge && enable;
            e_pvld = 0;
            m_len  = ncyc - ref_cyc;
            if (!enable) begin
                mode = M_OFF; good = 0;
                e_locked = 0; e_fault = 0; e_code = 0; e_period = 0;
            end else if (mode == M_OFF) begin
                mode = M_ACQ; ref_cyc = ncyc;
            end else if (mode == M_FAULT) begin
                if (clr_fault) begin
                    mode = M_ACQ; ref_cyc = ncyc; e_fault = 0; e_code = 0;
                end
            end else if (m_edge) begin
                if (mode == M_ACQ) begin
                    mode = M_TRACK; good = 0;
                end else begin
                    e_period = m_len; e_pvld = 1;
                    m_ok = (m_len >= EXP - TOL) && (m_len <= EXP + TOL);
                    if (mode == M_TRACK) begin
                        good = m_ok ? good + 1 : 0;
                        if (good == LOCKN) begin mode = M_LOCKED; e_locked = 1; end
                    end else if (!m_ok) begin
                        mode = M_FAULT; e_locked = 0; e_fault = 1; e_code = 1;
                    end
                end
                ref_cyc = ncyc;
            end else if (m_len > TMO) begin
                mode = M_FAULT; e_locked = 0; e_fault = 1; e_code = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (ncyc > 0) begin
            check("cmp_tick", tick, e_tick);
            check("cmp_period_vld", period_vld, e_pvld);
            check("cmp_period", period, e_period);
            check("cmp_locked", locked, e_locked);
            check("cmp_fault", fault, e_fault);
            check("cmp_fault_code", fault_code, e_code);
        end
    end

    // Event recorder for the directed literal checks.
    int tick_cnt = 0, pvld_cnt = 0, last_tick_cyc = 0, last_pvld_cyc = 0;
    int last_pvld_period = 0, lock_tick = 0, fault_rise_cyc = 0;
    bit prev_locked = 0, prev_fault = 0;

    always @(negedge clk) begin
        if (tick === 1'b1) begin tick_cnt++; last_tick_cyc = ncyc; end
        if (period_vld === 1'b1) begin
            pvld_cnt++; last_pvld_cyc = ncyc; last_pvld_period = int'(period);
        end
        if (locked === 1'b1 && !prev_locked) lock_tick = tick_cnt;
        if (fault === 1'b1 && !prev_fault) fault_rise_cyc = ncyc;
        prev_locked = (locked === 1'b1);
        prev_fault  = (fault === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lf_period(input int len);
        lfclk_in = 1'b1;
        cyc(len / 2);
        lfclk_in = 1'b0;
        cyc(len - len / 2);
    endtask

    int base;
    int snap;
    int t2_len[9] = '{480, 496, 479, 497, 480, 496, 480, 496, 488};

    initial begin
        cyc(3);
        #1;
        check("reset_outputs", {tick, period_vld, locked, fault, fault_code, period}, 0);

        // Nominal divider: lock on the 5th edge, every period 488.
        reset_n = 1'b1; enable = 1'b1;
        cyc(4);
        base = tick_cnt;
        repeat (7) lf_period(488);
        #1;
        check("t1_period", last_pvld_period, 488);
        check("t1_lock_edge", lock_tick - base, 5);
        check("t1_ticks", tick_cnt - base, 7);
        check("t1_locked", locked, 1);
        check("t1_fault", fault, 0);

        // Window boundaries: 480/496 good, 479/497 restart the run.
        enable = 1'b0; cyc(2); enable = 1'b1; cyc(4);
        for (int i = 0; i < 8; i++) lf_period(t2_len[i]);
        #1;
        check("t2_not_locked", locked, 0);
        check("t2_period_480", last_pvld_period, 480);
        lf_period(t2_len[8]);
        #1;
        check("t2_locked", locked, 1);
        check("t2_period_496", last_pvld_period, 496);

        // Lost clock after lock.
        snap = pvld_cnt;
        cyc(1100);
        #1;
        check("t3_fault", fault, 1);
        check("t3_code", fault_code, 2);
        check("t3_locked", locked, 0);
        check("t3_fault_delay", fault_rise_cyc - last_tick_cyc, 1025);
        check("t3_no_pvld", pvld_cnt - snap, 0);

        // Clear, relock, then one short period.
        clr_fault = 1'b1; cyc(1); clr_fault = 1'b0;
        #1;
        check("t5_cleared", fault, 0);
        check("t5_code_none", fault_code, 0);
        base = tick_cnt;
        repeat (6) lf_period(488);
        lf_period(470);
        lf_period(488);
        #1;
        check("t5_relock_edge", lock_tick - base, 5);
        check("t4_fault", fault, 1);
        check("t4_code", fault_code, 1);
        check("t4_period", last_pvld_period, 470);
        check("t4_same_cycle", fault_rise_cyc - last_pvld_cyc, 0);
        check("t4_locked", locked, 0);

        // clr_fault together with enable low: OFF wins.
        clr_fault = 1'b1; enable = 1'b0; cyc(1); clr_fault = 1'b0;
        #1;
        check("t5_off_outputs", {locked, fault, fault_code, period}, 0);

        // Relock, then a one-cycle reset with lfclk high.
        enable = 1'b1; cyc(4);
        repeat (6) lf_period(488);
        #1;
        check("t6_locked", locked, 1);
        lfclk_in = 1'b1; cyc(1);
        reset_n = 1'b0; cyc(1); reset_n = 1'b1;
        #1;
        check("t6_reset_outputs", {tick, period_vld, locked, fault, fault_code, period}, 0);
        base = tick_cnt;
        cyc(200);
        #1;
        check("t6_ticks_le1", (tick_cnt - base) <= 1, 1);
        check("t6_fault", fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
